rs_key_sched_seq: RTL and testbench
===================================

Name: rs_key_sched_seq

Overview:
- Sequential, resource-shared Reed-Solomon engine for the Twofish key schedule.
- Accepts a 128-bit key on a start handshake and produces the S-box key words S0 and S1.
- Feeds one key byte per cycle through 4 shared GF(2^8) multipliers (modulus 0x14D) instead of 64 parallel ones.
- Sits between the key-load interface and the g-function/S-box keying in both the encryption and decryption paths.

Parameters:
- GF_POLY, 9'h14D, field reduction polynomial x^8+x^6+x^3+x^2+1.
- KEY_W, 128, key width in bits; only 128 is supported.

Ports:
- clk  in  1  system clock; the only clock.
- rst  in  1  synchronous reset, active-high.
- start  in  1  request to compute; sampled only in IDLE.
- key  in  128  key; byte m0 = key[127:120] through m15 = key[7:0].
- busy  out  1  high while computing.
- done  out  1  one-cycle pulse; S0/S1 are valid.
- s0  out  32  {S03,S02,S01,S00}, computed from m0..m7.
- s1  out  32  {S13,S12,S11,S10}, computed from m8..m15.

Behaviour:
- Reset: rst high at a clk edge forces state=IDLE, busy=0, done=0, s0=0, s1=0, counter=0 and accumulators=0. This applies in any state; a computation in flight is abandoned and no done is produced.
- FSM states: IDLE, RUN, FIN.
- IDLE:
  - On start=1, latch key into key_r, clear both 32-bit accumulators, set cnt=0 and go to RUN.
  - s0/s1 keep their last values until a new start is accepted; they are then held until FIN overwrites them.
- RUN (busy=1):
  - Each cycle selects byte b = key_r[127-8*cnt -: 8].
  - Multiplies b by RS column j = cnt mod 8, giving 4 products (rows 0..3).
  - XORs product k into byte k of acc[cnt>>3].
  - cnt increments; after cnt==15 is processed, go to FIN.
- FIN:
  - s0 <= acc0, s1 <= acc1, done=1 for exactly this cycle, busy=0, then IDLE.
- RS columns as (row0,row1,row2,row3):
  - j0: 01,A4,02,A4
  - j1: A4,56,A1,55
  - j2: 55,82,FC,87
  - j3: 87,F3,C1,5A
  - j4: 5A,1E,47,58
  - j5: 58,C6,AE,DB
  - j6: DB,68,3D,9E
  - j7: 9E,E5,19,03
- Timing: start sampled at edge E. busy is high after edges E+1..E+16. done is high after edge E+17. The next start can be accepted at edge E+18 (start at E+17 coincides with done and is accepted only if the FSM is in IDLE, so it is ignored).
- start while busy or FIN is ignored. key is not sampled except at acceptance, so changes to key mid-run have no effect.
- GF multiply:
  - Shift-and-add over 8 bits, reducing by GF_POLY whenever bit 8 is set.
  - Purely combinational within one cycle; no carries and no integer arithmetic.

Optional Feature:
- Macro: RS_DUAL_LANE_EN.
- Defined:
  - 8 multipliers; bytes m_j and m_(j+8) are processed in the same cycle into acc0 and acc1.
  - RUN lasts 8 cycles (cnt 0..7); done follows after edge E+9.
- Undefined: 4 multipliers, 16-cycle RUN as above.
- Results are bit-identical in both builds.

Decomposition:
- Shared package twofish_pkg holds:
  - GF_POLY_RS = 9'h14D
  - the 8x4 RS column constant array
  - the state enum {IDLE, RUN, FIN}
- One sub-module, gf256_mul: combinational 8x8 multiply with a polynomial input, instantiated 4x (or 8x with RS_DUAL_LANE_EN).

Test Plan:
- Zero key: key=0, pulse start -> done at E+17 (E+9 dual-lane), s0=32'h0, s1=32'h0; busy high for exactly 16 (8) cycles.
- m0=01 (key=128'h01<<120) -> s0=32'hA402A401, s1=0.
- m7=01 and m15=01 (key=128'h0000000000000001_0000000000000001) -> s0=32'h0319E59E, s1=32'h0319E59E.
- Reduction path: m0=02, rest 0 -> s0=32'h05040502 (02*A4=05), s1=0.
- Start ignored while busy: start re-asserted at E+5 with a different key -> single done pulse at E+17, results match the first key.
- Reset mid-run: assert rst at E+8 -> busy=0, s0=s1=0 next cycle, no done pulse; then a fresh start computes correctly.

Source files
------------

// File: rtl/twofish_pkg.sv
// Shared Twofish key-schedule definitions: RS field polynomial,
// RS matrix columns and the RS engine state encoding.
package twofish_pkg;

  localparam logic [8:0] GF_POLY_RS = 9'h14D;

  // RS_MAT[j][k]: column j, row k.
  localparam logic [0:7][0:3][7:0] RS_MAT = {
    8'h01, 8'hA4, 8'h02, 8'hA4,
    8'hA4, 8'h56, 8'hA1, 8'h55,
    8'h55, 8'h82, 8'hFC, 8'h87,
    8'h87, 8'hF3, 8'hC1, 8'h5A,
    8'h5A, 8'h1E, 8'h47, 8'h58,
    8'h58, 8'hC6, 8'hAE, 8'hDB,
    8'hDB, 8'h68, 8'h3D, 8'h9E,
    8'h9E, 8'hE5, 8'h19, 8'h03
  };

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIN
  } rs_state_e;

endpackage

// File: rtl/gf256_mul.sv
// Combinational GF(2^8) multiply, shift-and-add with reduction.
// Ports: a_i, b_i operands; poly_i 9-bit modulus; p_o product.
module gf256_mul (
  input  logic [7:0] a_i,
  input  logic [7:0] b_i,
  input  logic [8:0] poly_i,
  output logic [7:0] p_o
);

  logic [8:0] sh;
  logic [7:0] acc;

  always_comb begin
    sh  = {1'b0, a_i};
    acc = '0;
    for (int i = 0; i < 8; i++) begin
      if (b_i[i]) acc = acc ^ sh[7:0];
      sh = {sh[7:0], 1'b0};
      // Fold x^8 back into the field.
      if (sh[8]) sh = sh ^ poly_i;
    end
    p_o = acc;
  end

endmodule

// File: rtl/rs_key_sched_seq.sv
// Sequential Reed-Solomon engine producing Twofish S-box key words.
// Ports: clk, rst (sync, active-high), start, key[127:0] in;
// busy, done (1-cycle pulse), s0, s1 out.
// Build option RS_DUAL_LANE_EN: 8 multipliers, 8-cycle run.
module rs_key_sched_seq
  import twofish_pkg::*;
#(
  parameter logic [8:0] GF_POLY = GF_POLY_RS,
  parameter int         KEY_W   = 128
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [KEY_W-1:0] key,
  output logic             busy,
  output logic             done,
  output logic [31:0]      s0,
  output logic [31:0]      s1
);

`ifdef RS_DUAL_LANE_EN
  localparam int CNT_W = 3;
`else
  localparam int CNT_W = 4;
`endif
  localparam logic [CNT_W-1:0] LAST = '1;

  rs_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [127:0]     key_q, key_d;
  logic [31:0]      acc0_q, acc0_d;
  logic [31:0]      acc1_q, acc1_d;
  logic [31:0]      s0_q, s0_d;
  logic [31:0]      s1_q, s1_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [2:0]       col;
  logic [7:0]       b0;
  logic [31:0]      pv0;

`ifdef RS_DUAL_LANE_EN
  logic [7:0]       b1;
  logic [31:0]      pv1;
  logic [6:0]       off;

  // Lane 0 walks m0..m7, lane 1 walks m8..m15 in step.
  assign col = cnt_q;
  assign off = {1'b0, cnt_q, 3'b000};
  assign b0  = key_q[7'd127 - off -: 8];
  assign b1  = key_q[7'd63 - off -: 8];

  for (genvar k = 0; k < 4; k++) begin : g_mul
    gf256_mul u_mul0 (
      .a_i    (b0),
      .b_i    (RS_MAT[col][k]),
      .poly_i (GF_POLY),
      .p_o    (pv0[8*k +: 8])
    );
    gf256_mul u_mul1 (
      .a_i    (b1),
      .b_i    (RS_MAT[col][k]),
      .poly_i (GF_POLY),
      .p_o    (pv1[8*k +: 8])
    );
  end
`else
  assign col = cnt_q[2:0];
  assign b0  = key_q[7'd127 - {cnt_q, 3'b000} -: 8];

  for (genvar k = 0; k < 4; k++) begin : g_mul
    gf256_mul u_mul0 (
      .a_i    (b0),
      .b_i    (RS_MAT[col][k]),
      .poly_i (GF_POLY),
      .p_o    (pv0[8*k +: 8])
    );
  end
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    key_d   = key_q;
    acc0_d  = acc0_q;
    acc1_d  = acc1_q;
    s0_d    = s0_q;
    s1_d    = s1_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          key_d   = key;
          acc0_d  = '0;
          acc1_d  = '0;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        // busy/done are registered, so they trail state by a cycle.
        busy_d = 1'b1;
`ifdef RS_DUAL_LANE_EN
        acc0_d = acc0_q ^ pv0;
        acc1_d = acc1_q ^ pv1;
`else
        if (cnt_q[3]) acc1_d = acc1_q ^ pv0;
        else          acc0_d = acc0_q ^ pv0;
`endif
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) state_d = FIN;
      end
      FIN: begin
        s0_d    = acc0_q;
        s1_d    = acc1_q;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      key_q   <= '0;
      acc0_q  <= '0;
      acc1_q  <= '0;
      s0_q    <= '0;
      s1_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      key_q   <= key_d;
      acc0_q  <= acc0_d;
      acc1_q  <= acc1_d;
      s0_q    <= s0_d;
      s1_q    <= s1_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign s0   = s0_q;
  assign s1   = s1_q;

endmodule

// File: tb/tb_rs_key_sched_seq.sv
// Self-checking bench for rs_key_sched_seq against a
// polynomial-arithmetic RS model; honours RS_DUAL_LANE_EN.
module tb_rs_key_sched_seq;

`ifdef RS_DUAL_LANE_EN
  localparam int RUNLEN = 8;
`else
  localparam int RUNLEN = 16;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [127:0] key;
  logic         busy;
  logic         done;
  logic [31:0]  s0;
  logic [31:0]  s1;

  int checks = 0;
  int errors = 0;

  localparam logic [31:0] COLS [8] = '{
    32'h01A402A4, 32'hA456A155, 32'h5582FC87, 32'h87F3C15A,
    32'h5A1E4758, 32'h58C6AEDB, 32'hDB683D9E, 32'h9EE51903
  };

  rs_key_sched_seq dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .key   (key),
    .busy  (busy),
    .done  (done),
    .s0    (s0),
    .s1    (s1)
  );

  always #5 clk = ~clk;

  // Full carry-less product, then long division by x^8+x^6+x^3+x^2+1.
  function automatic logic [7:0] gmul(input logic [7:0] a,
                                      input logic [7:0] b);
    logic [15:0] p;
    p = '0;
    for (int i = 0; i < 8; i++)
      if (b[i]) p = p ^ (16'(a) << i);
    for (int d = 15; d >= 8; d--)
      if (p[d]) p = p ^ (16'h014D << (d - 8));
    return p[7:0];
  endfunction

  function automatic logic [63:0] model(input logic [127:0] k);
    logic [7:0]  m;
    logic [31:0] c;
    logic [7:0]  sb [2][4];
    for (int i = 0; i < 2; i++)
      for (int r = 0; r < 4; r++) sb[i][r] = '0;
    for (int n = 0; n < 16; n++) begin
      m = 8'(k >> (120 - 8 * n));
      c = COLS[n % 8];
      for (int r = 0; r < 4; r++)
        sb[n / 8][r] ^= gmul(m, 8'(c >> (24 - 8 * r)));
    end
    return {sb[0][3], sb[0][2], sb[0][1], sb[0][0],
            sb[1][3], sb[1][2], sb[1][1], sb[1][0]};
  endfunction

  // Starts one op (edge E) and watches E+1..E+RUNLEN+4.
  // inj>0: a second start with key k2 is sampled at E+inj.
  task automatic exec(input logic [127:0] k, input int inj,
                      input logic [127:0] k2);
    logic [63:0] exp;
    logic [31:0] h0, h1, r0, r1;
    int nb, nd, dat, bfirst;
    bit held;
    exp = model(k);
    h0 = s0; h1 = s1; r0 = '0; r1 = '0;
    nb = 0; nd = 0; dat = -1; bfirst = -1; held = 1'b1;
    @(negedge clk);
    start = 1'b1; key = k;
    @(posedge clk); #1;
    start = 1'b0; key = $urandom();
    for (int i = 1; i <= RUNLEN + 4; i++) begin
      if (i == inj - 1) begin start = 1'b1; key = k2; end
      @(posedge clk); #1;
      if (i == inj) start = 1'b0;
      if (busy) begin
        nb++;
        if (bfirst < 0) bfirst = i;
      end
      if (i <= RUNLEN && (s0 !== h0 || s1 !== h1)) held = 1'b0;
      if (done) begin
        nd++; dat = i; r0 = s0; r1 = s1;
      end
    end
    checks++;
    if (nb != RUNLEN || bfirst != 1) begin
      errors++;
      $display("FAIL busy_window got %0d from %0d need %0d from 1",
               nb, bfirst, RUNLEN);
    end
    checks++;
    if (nd != 1 || dat != RUNLEN + 1) begin
      errors++;
      $display("FAIL done_pulse got %0d at %0d need 1 at %0d",
               nd, dat, RUNLEN + 1);
    end
    checks++;
    if (!held) begin
      errors++;
      $display("FAIL s_hold outputs changed before done");
    end
    checks++;
    if (r0 !== exp[63:32]) begin
      errors++;
      $display("FAIL s0 key=%h got %h need %h", k, r0, exp[63:32]);
    end
    checks++;
    if (r1 !== exp[31:0]) begin
      errors++;
      $display("FAIL s1 key=%h got %h need %h", k, r1, exp[31:0]);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; key = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    checks++;
    if ({busy, done, s0, s1} !== 66'b0) begin
      errors++;
      $display("FAIL reset got b=%b d=%b s0=%h s1=%h need zeros",
               busy, done, s0, s1);
    end
  endtask

  task automatic test_directed();
    logic [63:0] e;
    exec(128'h0, 0, 128'h0);
    exec(128'h01 << 120, 0, 128'h0);
    e = model(128'h01 << 120);
    checks++;
    if (e !== {32'hA402A401, 32'h0}) begin
      errors++;
      $display("FAIL model_m0 got %h need A402A40100000000", e);
    end
    exec(128'h0000000000000001_0000000000000001, 0, 128'h0);
    exec(128'h02 << 120, 0, 128'h0);
    checks++;
    if (s0 !== 32'h05040502 || s1 !== 32'h0) begin
      errors++;
      $display("FAIL reduction got %h %h need 05040502 0", s0, s1);
    end
  endtask

  task automatic test_random();
    logic [127:0] k;
    for (int n = 0; n < 20; n++) begin
      k = {$urandom(), $urandom(), $urandom(), $urandom()};
      exec(k, 0, 128'h0);
    end
  endtask

  task automatic test_start_ignored();
    logic [127:0] k, k2;
    k  = {$urandom(), $urandom(), $urandom(), $urandom()};
    k2 = ~k;
    exec(k, 5, k2);
  endtask

  task automatic test_reset_mid_run();
    int nd;
    @(negedge clk);
    start = 1'b1; key = {4{32'hDEADBEEF}};
    @(posedge clk); #1;
    start = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++;
    if ({busy, done, s0, s1} !== 66'b0) begin
      errors++;
      $display("FAIL mid_reset got b=%b d=%b s0=%h s1=%h need zeros",
               busy, done, s0, s1);
    end
    nd = 0;
    for (int i = 0; i < RUNLEN + 6; i++) begin
      @(posedge clk); #1;
      if (done || busy) nd++;
    end
    checks++;
    if (nd != 0) begin
      errors++;
      $display("FAIL abandoned got %0d active cycles need 0", nd);
    end
    exec(128'h0123456789ABCDEF_FEDCBA9876543210, 0, 128'h0);
  endtask

  task automatic test_back_to_back();
    logic [127:0] ka, kb;
    logic [63:0]  ea, eb;
    int d1, d2, nd, t2;
    ka = {$urandom(), $urandom(), $urandom(), $urandom()};
    kb = {$urandom(), $urandom(), $urandom(), $urandom()};
    ea = model(ka); eb = model(kb);
    t2 = 2 * RUNLEN + 3;
    d1 = -1; d2 = -1; nd = 0;
    @(negedge clk);
    start = 1'b1; key = ka;
    @(posedge clk); #1;
    key = kb;
    for (int i = 1; i <= 2 * RUNLEN + 8; i++) begin
      @(posedge clk); #1;
      if (i == RUNLEN + 2) start = 1'b0;
      if (done) begin
        nd++;
        if (nd == 1) begin
          d1 = i;
          checks++;
          if ({s0, s1} !== ea) begin
            errors++;
            $display("FAIL b2b_first got %h%h need %h", s0, s1, ea);
          end
        end else begin
          d2 = i;
          checks++;
          if ({s0, s1} !== eb) begin
            errors++;
            $display("FAIL b2b_second got %h%h need %h", s0, s1, eb);
          end
        end
      end
    end
    checks++;
    if (nd != 2 || d1 != RUNLEN + 1 || d2 != t2) begin
      errors++;
      $display("FAIL b2b_timing got %0d at %0d,%0d need 2 at %0d,%0d",
               nd, d1, d2, RUNLEN + 1, t2);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_start_ignored();
    test_reset_mid_run();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
